grant_collect: RTL and testbench

GRANT_COLLECT -- requirements
Module: grant_collect

---
 rtl/arb_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/grant_collect.sv | 91 +++++++++
 tb/tb_grant_collect.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the grant collector: requester count, source tag and queue entry.
package arb_pkg;
  localparam int NUM_REQ   = 4;
  localparam int PAYLOAD_W = 8;

  typedef logic [1:0] src_t;

  // Queue entry at the default payload width; the top packs {src, payload}
  // in the same order for any DW.
  typedef struct packed {
    src_t                 src;
    logic [PAYLOAD_W-1:0] data;
  } entry_t;

  // Index of the lowest set bit; 0 when none is set.
  function automatic src_t lowest_idx(input logic [NUM_REQ-1:0] v);
    src_t r;
    r = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) r = src_t'(i);
    end
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth, head read combinationally from storage.
module sync_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rptr_q];

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push alongside it.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointers/count; pointers wrap naturally at AW bits.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset; stale words are masked by the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end
endmodule

// File: rtl/grant_collect.sv
// Turns rising edges on four sticky grant lines into queued {src, payload} entries.
module grant_collect
  import arb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ack0,
  input  logic                   ack1,
  input  logic                   ack2,
  input  logic                   ack3,
  input  logic [DW-1:0]          data0,
  input  logic [DW-1:0]          data1,
  input  logic [DW-1:0]          data2,
  input  logic [DW-1:0]          data3,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DW-1:0]          out_data,
  output logic [1:0]             out_src,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf,
  output logic                   err
);
  localparam int SW = $bits(src_t);
  localparam int EW = SW + DW;

  logic [NUM_REQ-1:0] ack_vec, ack_q, rise;
  logic               push, pop, multi, drop, full, empty;
  src_t               sel;
  logic [DW-1:0]      data_sel;
  logic [EW-1:0]      head;
  logic               ovf_q, ovf_d, err_q, err_d;

  assign ack_vec = {ack3, ack2, ack1, ack0};
  assign rise    = ack_vec & ~ack_q;
  assign push    = |rise;
  assign multi   = |(rise & (rise - 1'b1));
  assign sel     = lowest_idx(rise);
  assign pop     = out_valid && out_ready;
  assign drop    = push && full && !pop;

  // Payload of the winning requester.
  always_comb begin
    data_sel = data0;
    case (sel)
      2'd1:    data_sel = data1;
      2'd2:    data_sel = data2;
      2'd3:    data_sel = data3;
      default: data_sel = data0;
    endcase
  end

  // Sticky flags only ever set; cleared solely by reset.
  always_comb begin
    ovf_d = ovf_q | drop;
    err_d = err_q | multi;
  end

  // Ack history and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= ack_vec;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({sel, data_sel}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign out_valid = !empty;
  assign out_src   = head[EW-1 -: SW];
  assign out_data  = head[DW-1:0];
  assign ovf       = ovf_q;
  assign err       = err_q;
endmodule

// File: tb/tb_grant_collect.sv
// Bench for grant_collect: fixed vector table plus a queue-based scoreboard model.
module tb_grant_collect;
  import arb_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ack0, ack1, ack2, ack3;
  logic [DW-1:0] data0, data1, data2, data3;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic [2:0]    count;
  logic          ovf, err;

  grant_collect #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ack0(ack0), .ack1(ack1), .ack2(ack2), .ack3(ack3),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src),
    .count(count), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  a;
    logic [31:0] d;
    logic        rd;
    int          cnt;
    logic        vld;
    int          src;
    int          dat;
    logic        eovf;
    logic        eerr;
  } vec_t;

  vec_t   vecs[$];
  entry_t mq[$];
  logic [3:0] mack;
  logic   movf, merr;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] a, input logic [31:0] d, input logic rd,
                     input int cnt, input logic vld, input int src, input int dat,
                     input logic eovf, input logic eerr);
    vec_t v;
    v.r = r; v.a = a; v.d = d; v.rd = rd; v.cnt = cnt; v.vld = vld;
    v.src = src; v.dat = dat; v.eovf = eovf; v.eerr = eerr;
    vecs.push_back(v);
  endtask

  // One clock: drive inputs after the falling edge, update the model at the
  // rising edge, then compare DUT state against the model at the next falling edge.
  task automatic step(input logic r, input logic [3:0] a, input logic [31:0] d, input logic rd);
    entry_t     e;
    logic [3:0] rs;
    int         sz, idx;
    logic       popped;
    rst = r; {ack3, ack2, ack1, ack0} = a; out_ready = rd;
    {data3, data2, data1, data0} = d;
    #1;
    popped = 1'b0;
    sz = mq.size();
    if (r) begin
      mq.delete(); mack = '0; movf = 1'b0; merr = 1'b0;
    end else begin
      if (sz != 0 && rd) begin
        e = mq.pop_front();
        popped = 1'b1;
        chk("pop_valid", 32'(out_valid), 32'd1);
        chk("pop_src", 32'(out_src), 32'(e.src));
        chk("pop_data", 32'(out_data), 32'(e.data));
      end
      rs = a & ~mack;
      if (rs != 4'd0) begin
        idx = 0;
        for (int i = 3; i >= 0; i--) if (rs[i]) idx = i;
        if (sz == DEPTH && !popped) movf = 1'b1;
        else begin
          e.src = src_t'(idx);
          e.data = d[idx*8 +: 8];
          mq.push_back(e);
        end
        if ($countones(rs) > 1) merr = 1'b1;
      end
      mack = a;
    end
    @(posedge clk);
    @(negedge clk);
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("m_ovf", 32'(ovf), 32'(movf));
    chk("m_err", 32'(err), 32'(merr));
    if (mq.size() != 0) begin
      chk("m_head_src", 32'(out_src), 32'(mq[0].src));
      chk("m_head_data", 32'(out_data), 32'(mq[0].data));
    end
  endtask

  initial begin
    int cyc;
    logic [3:0] a;
    logic [31:0] d;
    rst = 1'b1; ack0 = 0; ack1 = 0; ack2 = 0; ack3 = 0;
    data0 = '0; data1 = '0; data2 = '0; data3 = '0; out_ready = 0;
    mack = '0; movf = 0; merr = 0;
    @(negedge clk);

    // rst a d rd | cnt vld src dat ovf err
    add(1, 4'b0000, 32'h0,        0, 0, 0, 0, 0,     0, 0);
    add(1, 4'b0000, 32'h0,        0, 0, 0, 0, 0,     0, 0);
    // ack2 held 3 cycles -> one entry
    add(0, 4'b0100, 32'h005A0000, 0, 1, 1, 2, 'h5A,  0, 0);
    add(0, 4'b0100, 32'h005A0000, 0, 1, 1, 2, 'h5A,  0, 0);
    add(0, 4'b0100, 32'h005A0000, 0, 1, 1, 2, 'h5A,  0, 0);
    add(0, 4'b0000, 32'h0,        1, 0, 0, 0, 0,     0, 0);
    // ack1+ack3 together -> src1 only, err
    add(0, 4'b1010, 32'h33001100, 0, 1, 1, 1, 'h11,  0, 1);
    add(0, 4'b0000, 32'h0,        1, 0, 0, 0, 0,     0, 1);
    // five events with no consumer -> full, fifth dropped
    add(0, 4'b0001, 32'h000000A0, 0, 1, 1, 0, 'hA0,  0, 1);
    add(0, 4'b0010, 32'h0000A100, 0, 2, 1, 0, 'hA0,  0, 1);
    add(0, 4'b0100, 32'h00A20000, 0, 3, 1, 0, 'hA0,  0, 1);
    add(0, 4'b1000, 32'hA3000000, 0, 4, 1, 0, 'hA0,  0, 1);
    add(0, 4'b0001, 32'h000000A4, 0, 4, 1, 0, 'hA0,  1, 1);
    // push+pop while full, then drain to see B1 at the tail
    add(0, 4'b0010, 32'h0000B100, 1, 4, 1, 1, 'hA1,  1, 1);
    add(0, 4'b0000, 32'h0,        1, 3, 1, 2, 'hA2,  1, 1);
    add(0, 4'b0000, 32'h0,        1, 2, 1, 3, 'hA3,  1, 1);
    add(0, 4'b0000, 32'h0,        1, 1, 1, 1, 'hB1,  1, 1);
    add(0, 4'b0000, 32'h0,        1, 0, 0, 0, 0,     1, 1);
    // three queued, reset with ack2 held, then ack2 re-fires once
    add(0, 4'b0001, 32'h000000C0, 0, 1, 1, 0, 'hC0,  1, 1);
    add(0, 4'b0010, 32'h0000C100, 0, 2, 1, 0, 'hC0,  1, 1);
    add(0, 4'b0100, 32'h00C20000, 0, 3, 1, 0, 'hC0,  1, 1);
    add(1, 4'b0100, 32'h00C20000, 0, 0, 0, 0, 0,     0, 0);
    add(0, 4'b0100, 32'h00C20000, 0, 1, 1, 2, 'hC2,  0, 0);
    add(0, 4'b0100, 32'h00C20000, 0, 1, 1, 2, 'hC2,  0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].rd);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].vld));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].eovf));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].eerr));
      if (vecs[i].vld) begin
        chk($sformatf("v%0d_src", i), 32'(out_src), 32'(vecs[i].src));
        chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].dat));
      end
    end

    // drain, then 10 events across all lanes with out_ready toggling each cycle
    step(0, 4'b0000, 32'h0, 1);
    step(0, 4'b0000, 32'h0, 1);
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      a = 4'b0001 << (i % 4);
      d = 32'($urandom_range(255)) << ((i % 4) * 8);
      step(0, a, d, cyc[0]);
      cyc++;
      step(0, 4'b0000, 32'h0, cyc[0]);
      cyc++;
    end
    for (int i = 0; i < 8; i++) step(0, 4'b0000, 32'h0, 1);
    chk("wrap_no_loss_ovf", 32'(ovf), 32'd0);
    chk("wrap_drained", 32'(count), 32'd0);

    // out_ready with an empty queue must not disturb anything
    step(0, 4'b0000, 32'h0, 1);
    chk("empty_ready_count", 32'(count), 32'd0);
    chk("empty_ready_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
